// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared types and constants for the MMIO write bridge
package mmio_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_UNMAPPED = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_t;

    localparam logic [11:0] PERIPH_BASE_DEFAULT = 12'h800;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_write_bridge_decode.sv
// rtl/mmio_write_bridge_decode.sv - address decode into DMEM / peripheral channel index
module mmio_decode
    import mmio_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          NCH         = 8,
    parameter logic [11:0] PERIPH_BASE = PERIPH_BASE_DEFAULT,
    parameter int          IDX_W       = idx_width(NCH)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              is_periph,
    output logic              hit,
    output logic [IDX_W-1:0]  index
);

    logic [11:0] offset;
    logic [9:0]  slot;
    logic        unused_bits;

    // Addresses below PERIPH_BASE wrap to a huge slot and therefore miss.
    always_comb begin
        offset    = addr[11:0] - PERIPH_BASE;
        slot      = offset[11:2];
        is_periph = addr[11];
        hit       = is_periph && (addr[1:0] == 2'b00) && ({22'd0, slot} < 32'(NCH));
        index     = slot[IDX_W-1:0];
    end

    assign unused_bits = ^{addr[ADDR_W-1:12], offset[1:0], slot};

endmodule

// File: rtl/mmio_write_bridge.sv
// rtl/mmio_write_bridge.sv - MEM-stage store bridge to NCH peripherals; MMIO_POSTED_WRITE_EN selects posted stores
module mmio_write_bridge
    import mmio_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          NCH         = 8,
    parameter logic [11:0] PERIPH_BASE = PERIPH_BASE_DEFAULT,
    parameter int          TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  dmem_we,
    output logic                  stall,
    output logic [NCH-1:0]        ch_we,
    output logic [DATA_W-1:0]     ch_wdata,
    input  logic [NCH-1:0]        ch_ready,
    input  logic [NCH*DATA_W-1:0] ch_rdata,
    output logic [DATA_W-1:0]     rdata,
    input  logic                  err_clr,
    output logic [1:0]            err
);

    localparam int IDX_W = idx_width(NCH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic             is_periph;
    logic             hit;
    logic [IDX_W-1:0] index;

    mmio_decode #(
        .ADDR_W      (ADDR_W),
        .NCH         (NCH),
        .PERIPH_BASE (PERIPH_BASE),
        .IDX_W       (IDX_W)
    ) u_decode (
        .addr      (addr),
        .is_periph (is_periph),
        .hit       (hit),
        .index     (index)
    );

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] sel;
    err_t             err_r;

    logic             handshake;
    logic             tmo_abort;
    logic             done;
    logic             accept;
    logic             unmapped;
    logic             stall_raw;
    err_t             new_err;
    logic [NCH-1:0]   onehot;

    always_comb begin
        handshake = (state == BUSY) && ch_ready[sel] && ch_we[sel];
        tmo_abort = (state == BUSY) && !ch_ready[sel] && (cnt == CNT_W'(TIMEOUT - 1));
        done      = handshake || tmo_abort;
        accept    = (state == IDLE) && we && hit;
        unmapped  = we && is_periph && !hit;
`ifdef MMIO_POSTED_WRITE_EN
        // Only a second peripheral access has to wait for the buffer to drain.
        stall_raw = (state == BUSY) && (we || re) && hit;
`else
        // The store itself holds the pipeline until it is acknowledged or aborted.
        stall_raw = (state == IDLE) ? (we && hit) : !done;
`endif
        stall     = !rst && stall_raw;
        dmem_we   = we && !addr[11];
        rdata     = (re && hit) ? ch_rdata[index*DATA_W +: DATA_W] : '0;
        err       = err_r;
    end

    always_comb begin
        new_err = ERR_NONE;
        if (tmo_abort) begin
            new_err = ERR_TIMEOUT;
        end else if (unmapped) begin
            new_err = ERR_UNMAPPED;
        end
    end

    always_comb begin
        onehot        = '0;
        onehot[index] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sel      <= '0;
            ch_we    <= '0;
            ch_wdata <= '0;
            err_r    <= ERR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= BUSY;
                        sel      <= index;
                        ch_we    <= onehot;
                        ch_wdata <= wdata;
                        cnt      <= '0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state <= IDLE;
                        ch_we <= '0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ch_we <= '0;
                    cnt   <= '0;
                end
            endcase

            // A fresh error beats a simultaneous clear.
            if (new_err != ERR_NONE) begin
                err_r <= new_err;
            end else if (err_clr) begin
                err_r <= ERR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_mmio_write_bridge.sv
// tb/tb_mmio_write_bridge.sv - directed self-checking bench for mmio_write_bridge
module tb_mmio_write_bridge;

    localparam int NCH = 8;
    localparam int DW  = 32;
    localparam int AW  = 32;
`ifdef MMIO_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     addr;
    logic              we;
    logic              re;
    logic [DW-1:0]     wdata;
    logic              dmem_we;
    logic              stall;
    logic [NCH-1:0]    ch_we;
    logic [DW-1:0]     ch_wdata;
    logic [NCH-1:0]    ch_ready;
    logic [NCH*DW-1:0] ch_rdata;
    logic [DW-1:0]     rdata;
    logic              err_clr;
    logic [1:0]        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mmio_write_bridge #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .NCH         (NCH),
        .PERIPH_BASE (12'h800),
        .TIMEOUT     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .we       (we),
        .re       (re),
        .wdata    (wdata),
        .dmem_we  (dmem_we),
        .stall    (stall),
        .ch_we    (ch_we),
        .ch_wdata (ch_wdata),
        .ch_ready (ch_ready),
        .ch_rdata (ch_rdata),
        .rdata    (rdata),
        .err_clr  (err_clr),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; addr = '0; we = 1'b0; re = 1'b0; wdata = '0;
        ch_ready = '0; err_clr = 1'b0;
        for (int k = 0; k < NCH; k++) ch_rdata[k*DW +: DW] = 32'hC0DE_0000 + k;

        // reset state, with a peripheral store request present
        tick(); tick();
        we = 1'b1; addr = 32'h804; wdata = 32'hFF;
        @(negedge clk);
        chk("rst_ch_we", ch_we, 0);
        chk("rst_ch_wdata", ch_wdata, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);
        tick(); rst = 1'b0; we = 1'b0;

        // DMEM store
        tick(); we = 1'b1; addr = 32'h100; wdata = 32'h1234;
        @(negedge clk);
        chk("dmem_we", dmem_we, 1);
        chk("dmem_ch_we", ch_we, 0);
        chk("dmem_stall", stall, 0);
        tick(); we = 1'b0;
        @(negedge clk);
        chk("dmem_we_off", dmem_we, 0);

        // loads
        tick(); re = 1'b1; addr = 32'h80C;
        @(negedge clk); chk("rd_ch3", rdata, 32'hC0DE_0003);
        tick(); addr = 32'h81C;
        @(negedge clk); chk("rd_ch7", rdata, 32'hC0DE_0007);
        tick(); addr = 32'h840;
        @(negedge clk); chk("rd_unmapped", rdata, 0);
        tick(); addr = 32'h806;
        @(negedge clk); chk("rd_misaligned", rdata, 0);
        tick(); addr = 32'h00C;
        @(negedge clk); chk("rd_dmem", rdata, 0);
        tick(); re = 1'b0;

        // store with immediate ready
        tick(); we = 1'b1; addr = 32'h804; wdata = 32'hA5; ch_ready = 8'h02;
        @(negedge clk);
        chk("st_t0_stall", stall, !POSTED);
        chk("st_t0_ch_we", ch_we, 0);
        chk("st_t0_dmem_we", dmem_we, 0);
        tick(); if (POSTED) we = 1'b0;
        @(negedge clk);
        chk("st_t1_ch_we", ch_we, 8'h02);
        chk("st_t1_ch_wdata", ch_wdata, 32'hA5);
        chk("st_t1_stall", stall, 0);
        tick(); we = 1'b0; ch_ready = '0;
        @(negedge clk);
        chk("st_t2_ch_we", ch_we, 0);
        chk("st_t2_stall", stall, 0);

        // timeout abort after 4 valid cycles
        tick(); we = 1'b1; addr = 32'h804; wdata = 32'h5A;
        @(negedge clk);
        chk("to_t0_stall", stall, !POSTED);
        tick(); if (POSTED) we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("to_busy%0d_ch_we", i), ch_we, 8'h02);
            chk($sformatf("to_busy%0d_stall", i), stall, !POSTED && (i < 3));
            chk($sformatf("to_busy%0d_err", i), err, 0);
            tick();
        end
        we = 1'b0;
        @(negedge clk);
        chk("to_after_ch_we", ch_we, 0);
        chk("to_after_err", err, 2'b10);
        chk("to_after_stall", stall, 0);
        tick(); err_clr = 1'b1;
        @(negedge clk); chk("to_clr_same_cycle", err, 2'b10);
        tick(); err_clr = 1'b0;
        @(negedge clk); chk("to_cleared", err, 0);

        // unmapped store with simultaneous clear: error wins
        tick(); we = 1'b1; addr = 32'h840; wdata = 32'hEE; err_clr = 1'b1;
        @(negedge clk);
        chk("um_stall", stall, 0);
        chk("um_dmem_we", dmem_we, 0);
        chk("um_ch_we", ch_we, 0);
        tick(); we = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        chk("um_err", err, 2'b01);
        chk("um_ch_we_after", ch_we, 0);
        chk("um_wdata_kept", ch_wdata, 32'h5A);
        tick(); err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        @(negedge clk); chk("um_cleared", err, 0);

        // misaligned peripheral store is also unmapped
        tick(); we = 1'b1; addr = 32'h806;
        @(negedge clk); chk("mis_stall", stall, 0);
        tick(); we = 1'b0;
        @(negedge clk);
        chk("mis_err", err, 2'b01);
        chk("mis_ch_we", ch_we, 0);
        tick(); err_clr = 1'b1;
        tick(); err_clr = 1'b0;

`ifdef MMIO_POSTED_WRITE_EN
        // posted: second store waits for the first to drain
        tick(); we = 1'b1; addr = 32'h800; wdata = 32'h11;
        @(negedge clk); chk("pw_first_stall", stall, 0);
        tick(); addr = 32'h808; wdata = 32'h22;
        @(negedge clk);
        chk("pw_b0_ch_we", ch_we, 8'h01);
        chk("pw_b0_wdata", ch_wdata, 32'h11);
        chk("pw_b0_stall", stall, 1);
        tick();
        @(negedge clk); chk("pw_b1_stall", stall, 1);
        tick(); ch_ready = 8'h01;
        @(negedge clk);
        chk("pw_b2_ch_we", ch_we, 8'h01);
        chk("pw_b2_stall", stall, 1);
        tick(); ch_ready = '0;
        @(negedge clk);
        chk("pw_idle_ch_we", ch_we, 0);
        chk("pw_idle_stall", stall, 0);
        tick(); we = 1'b0; ch_ready = 8'h04;
        @(negedge clk);
        chk("pw_second_ch_we", ch_we, 8'h04);
        chk("pw_second_wdata", ch_wdata, 32'h22);
        chk("pw_second_stall", stall, 0);
        tick(); ch_ready = '0;
        @(negedge clk); chk("pw_done_ch_we", ch_we, 0);
`endif

        // reset in the middle of a transfer
        tick(); we = 1'b1; addr = 32'h808; wdata = 32'h77; ch_ready = '0;
        @(negedge clk); chk("rb_t0_stall", stall, !POSTED);
        tick(); if (POSTED) we = 1'b0;
        @(negedge clk); chk("rb_busy_ch_we", ch_we, 8'h04);
        tick(); rst = 1'b1; we = 1'b0;
        @(negedge clk);
        chk("rb_rst_stall", stall, 0);
        chk("rb_rst_before_edge", ch_we, 8'h04);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rb_after_ch_we", ch_we, 0);
        chk("rb_after_wdata", ch_wdata, 0);
        chk("rb_after_err", err, 0);

        // fresh store after reset
        tick(); we = 1'b1; addr = 32'h80C; wdata = 32'h99; ch_ready = 8'h08;
        @(negedge clk); chk("fr_t0_stall", stall, !POSTED);
        tick(); if (POSTED) we = 1'b0;
        @(negedge clk);
        chk("fr_t1_ch_we", ch_we, 8'h08);
        chk("fr_t1_wdata", ch_wdata, 32'h99);
        chk("fr_t1_stall", stall, 0);
        tick(); we = 1'b0; ch_ready = '0;
        @(negedge clk);
        chk("fr_t2_ch_we", ch_we, 0);
        chk("fr_t2_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
